// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - IF/EX branch traffic and predictor/flush feedback bundle
// master = pipeline side (fetch and execute), slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_pc;
  logic [XLEN-1:0]  pred_target;
  logic             ex_branch;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;
  logic             stall_if;
  logic             upd_valid;
  logic             upd_outcome;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             orphan_err;
  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispredict;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output ex_branch, ex_taken, ex_target,
    input  stall_if, upd_valid, upd_outcome, flush,
    input  redirect_valid, redirect_pc, orphan_err,
    input  cnt_branches, cnt_mispredict
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  ex_branch, ex_taken, ex_target,
    output stall_if, upd_valid, upd_outcome, flush,
    output redirect_valid, redirect_pc, orphan_err,
    output cnt_branches, cnt_mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch resolution, predictor update and flush/redirect
// In-flight queue of predicted branches popped by EX; a mispredict clears it and holds flush.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  branch_resolve_unit_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             upd_valid_q, upd_valid_d;
  logic             upd_outcome_q, upd_outcome_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             orphan_q, orphan_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;

  logic             taken_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  tgt_mem   [DEPTH];

  logic             in_idle;
  logic             pop;
  logic             orphan_hit;
  logic             full;
  logic             stall;
  logic             push;
  logic             head_taken;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_target;
  logic             mispredict;

  assign in_idle     = (state_q == S_IDLE);
  assign pop         = bus.ex_branch && in_idle && (occ_q != '0);
  assign orphan_hit  = bus.ex_branch && in_idle && (occ_q == '0);
  assign full        = (occ_q == OCC_W'(DEPTH));
  // A same-cycle pop frees a slot, so a full queue still accepts the push.
  assign stall       = full && !pop && in_idle;
  assign push        = bus.pred_valid && !stall && in_idle;
  assign head_taken  = taken_mem[rd_ptr_q];
  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_target = tgt_mem[rd_ptr_q];
  assign mispredict  = pop && ((head_taken != bus.ex_taken) ||
                               (bus.ex_taken && (head_target != bus.ex_target)));

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    occ_d            = occ_q;
    upd_valid_d      = 1'b0;
    upd_outcome_d    = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    orphan_d         = orphan_q | orphan_hit;
    cnt_br_d         = cnt_br_q;
    cnt_mp_d         = cnt_mp_q;

    case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          state_d = S_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      upd_valid_d   = 1'b1;
      upd_outcome_d = bus.ex_taken;
      if (cnt_br_q != {CNT_W{1'b1}}) begin
        cnt_br_d = cnt_br_q + CNT_W'(1);
      end
      if (mispredict && (cnt_mp_q != {CNT_W{1'b1}})) begin
        cnt_mp_d = cnt_mp_q + CNT_W'(1);
      end
    end

    // Mispredict discards everything younger, including a push landing this cycle.
    if (mispredict) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = bus.ex_taken ? bus.ex_target : head_pc + XLEN'(4);
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      occ_d            = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      fcnt_q           <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      upd_valid_q      <= 1'b0;
      upd_outcome_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      orphan_q         <= 1'b0;
      cnt_br_q         <= '0;
      cnt_mp_q         <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      upd_valid_q      <= upd_valid_d;
      upd_outcome_q    <= upd_outcome_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      orphan_q         <= orphan_d;
      cnt_br_q         <= cnt_br_d;
      cnt_mp_q         <= cnt_mp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      taken_mem[wr_ptr_q] <= bus.pred_taken;
      pc_mem[wr_ptr_q]    <= bus.pred_pc;
      tgt_mem[wr_ptr_q]   <= bus.pred_target;
    end
  end

  assign bus.stall_if       = stall;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_outcome    = upd_outcome_q;
  assign bus.flush          = (state_q == S_FLUSH);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.orphan_err     = orphan_q;
  assign bus.cnt_branches   = cnt_br_q;
  assign bus.cnt_mispredict = cnt_mp_q;
endmodule
